// File: rtl/sat_pkg.sv
// Shared definitions for the sat_engine read-back path: entry types written
// to the bin store, the unloader FSM states and the literal encoding.
package sat_pkg;

    localparam logic [1:0] WR_TYPE_CLAUSE = 2'd0;
    localparam logic [1:0] WR_TYPE_VAR    = 2'd1;
    localparam logic [1:0] WR_TYPE_LVL    = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD_C,
        WAIT_C,
        WR_C,
        WR_V,
        WR_L,
        DONE
    } unload_state_t;

    // Two-bit literal encoding used inside a clause word.
    localparam logic [1:0] LIT_NONE = 2'd0;
    localparam logic [1:0] LIT_NEG  = 2'd1;
    localparam logic [1:0] LIT_POS  = 2'd2;

endpackage

// File: rtl/sat_engine_unloader.sv
// Reads one sat_engine bin back after the core finishes: strobes every clause
// slot, snapshots variable and level state, and streams all entries to the
// bin store over a registered valid/ready write channel.
module sat_engine_unloader
    import sat_pkg::*;
#(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int RD_LATENCY       = 1,
    parameter int WIDTH_DATA       = 19
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic [WIDTH_BIN_ID-1:0]              bin_id_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [NUM_CLAUSES-1:0]               rd_carray_o,
    input  logic [NUM_VARS*2-1:0]                clause_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
    output logic                                 wr_valid_o,
    input  logic                                 wr_ready_i,
    output logic [1:0]                           wr_type_o,
    output logic [WIDTH_BIN_ID-1:0]              wr_bin_o,
    output logic [3:0]                           wr_idx_o,
    output logic [WIDTH_DATA-1:0]                wr_data_o,
    output logic [3:0]                           nz_clause_cnt_o
);

    unload_state_t                        state_q;
    logic [WIDTH_BIN_ID-1:0]              bin_q;
    logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_q;
    logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_q;
    logic [NUM_VARS*2-1:0]                hold_q;
    logic [3:0]                           idx_q;
    logic [1:0]                           wait_q;
    logic [3:0]                           nz_q;
    logic [3:0]                           nz_cnt_q;
    logic                                 busy_q;
    logic                                 done_q;
    logic [NUM_CLAUSES-1:0]               rd_q;
    logic                                 valid_q;
    logic [1:0]                           type_q;
    logic [WIDTH_DATA-1:0]                data_q;

    function automatic logic [NUM_CLAUSES-1:0] strobe(input logic [3:0] i);
        return NUM_CLAUSES'(1) << i;
    endfunction

    function automatic logic [WIDTH_DATA-1:0] var_slice(input logic [3:0] i);
        return WIDTH_DATA'(vars_q[i*WIDTH_VAR_STATES +: WIDTH_VAR_STATES]);
    endfunction

    function automatic logic [WIDTH_DATA-1:0] lvl_slice(input logic [3:0] i);
        return WIDTH_DATA'(lvl_q[i*WIDTH_LVL_STATES +: WIDTH_LVL_STATES]);
    endfunction

    // Unload sequencer; every output is a register updated on state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            vars_q   <= '0;
            lvl_q    <= '0;
            hold_q   <= '0;
            idx_q    <= '0;
            wait_q   <= '0;
            nz_q     <= '0;
            nz_cnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= '0;
            valid_q  <= 1'b0;
            type_q   <= WR_TYPE_CLAUSE;
            data_q   <= '0;
        end else begin
            // Strobe and done are single-cycle pulses unless re-armed below.
            done_q <= 1'b0;
            rd_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        bin_q   <= bin_id_i;
                        vars_q  <= vars_states_i;
                        lvl_q   <= lvl_states_i;
                        idx_q   <= '0;
                        nz_q    <= '0;
                        busy_q  <= 1'b1;
                        rd_q    <= strobe(4'd0);
                        state_q <= RD_C;
                    end
                end
                RD_C: begin
                    wait_q  <= '0;
                    state_q <= WAIT_C;
                end
                WAIT_C: begin
                    if (wait_q == 2'(RD_LATENCY - 1)) begin
                        hold_q  <= clause_i;
                        data_q  <= WIDTH_DATA'(clause_i);
                        type_q  <= WR_TYPE_CLAUSE;
                        valid_q <= 1'b1;
                        state_q <= WR_C;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                WR_C: begin
                    if (wr_ready_i) begin
                        if (hold_q != '0) begin
                            nz_q <= nz_q + 4'd1;
                        end
                        if (idx_q == 4'(NUM_CLAUSES - 1)) begin
                            idx_q   <= '0;
                            type_q  <= WR_TYPE_VAR;
                            data_q  <= var_slice(4'd0);
                            state_q <= WR_V;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            valid_q <= 1'b0;
                            rd_q    <= strobe(idx_q + 4'd1);
                            state_q <= RD_C;
                        end
                    end
                end
                WR_V: begin
                    if (wr_ready_i) begin
                        if (idx_q == 4'(NUM_VARS - 1)) begin
                            idx_q   <= '0;
                            type_q  <= WR_TYPE_LVL;
                            data_q  <= lvl_slice(4'd0);
                            state_q <= WR_L;
                        end else begin
                            idx_q  <= idx_q + 4'd1;
                            data_q <= var_slice(idx_q + 4'd1);
                        end
                    end
                end
                WR_L: begin
                    if (wr_ready_i) begin
                        if (idx_q == 4'(NUM_LVLS - 1)) begin
                            idx_q    <= '0;
                            valid_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            nz_cnt_q <= nz_q;
                            state_q  <= DONE;
                        end else begin
                            idx_q  <= idx_q + 4'd1;
                            data_q <= lvl_slice(idx_q + 4'd1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign rd_carray_o     = rd_q;
    assign wr_valid_o      = valid_q;
    assign wr_type_o       = type_q;
    assign wr_bin_o        = bin_q;
    assign wr_idx_o        = idx_q;
    assign wr_data_o       = data_q;
    assign nz_clause_cnt_o = nz_cnt_q;

endmodule

// File: tb/tb_sat_engine_unloader.sv
// Bench for sat_engine_unloader: two instances (read latency 1 and 3) share
// stimulus, each fed by a small engine clause-array model; writes are checked
// against a queue of expected entries built when each unload is started.
module tb_sat_engine_unloader;
    import sat_pkg::*;

    localparam int NC  = 8;
    localparam int NV  = 8;
    localparam int NL  = 8;
    localparam int WVS = 19;
    localparam int WLS = 11;
    localparam int WD  = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                start1, start3;
    logic [9:0]          bin_id;
    logic [NV*2-1:0]     clause1, clause3;
    logic [WVS*NV-1:0]   vars;
    logic [WLS*NL-1:0]   lvls;
    logic                ready;

    logic busy1, done1, valid1, busy3, done3, valid3;
    logic [NC-1:0] rd1, rd3;
    logic [1:0] type1, type3;
    logic [9:0] bin1, bin3;
    logic [3:0] idx1, idx3, nz1, nz3;
    logic [WD-1:0] data1, data3;

    sat_engine_unloader #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .bin_id_i(bin_id),
        .busy_o(busy1), .done_o(done1), .rd_carray_o(rd1), .clause_i(clause1),
        .vars_states_i(vars), .lvl_states_i(lvls), .wr_valid_o(valid1),
        .wr_ready_i(ready), .wr_type_o(type1), .wr_bin_o(bin1), .wr_idx_o(idx1),
        .wr_data_o(data1), .nz_clause_cnt_o(nz1)
    );

    sat_engine_unloader #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .start_i(start3), .bin_id_i(bin_id),
        .busy_o(busy3), .done_o(done3), .rd_carray_o(rd3), .clause_i(clause3),
        .vars_states_i(vars), .lvl_states_i(lvls), .wr_valid_o(valid3),
        .wr_ready_i(ready), .wr_type_o(type3), .wr_bin_o(bin3), .wr_idx_o(idx3),
        .wr_data_o(data3), .nz_clause_cnt_o(nz3)
    );

    // Observed instance
    logic sel3;
    logic o_busy, o_done, o_valid;
    logic [NC-1:0] o_rd;
    logic [1:0] o_type;
    logic [9:0] o_bin;
    logic [3:0] o_idx, o_nz;
    logic [WD-1:0] o_data;

    always_comb begin
        o_busy  = sel3 ? busy3  : busy1;
        o_done  = sel3 ? done3  : done1;
        o_valid = sel3 ? valid3 : valid1;
        o_rd    = sel3 ? rd3    : rd1;
        o_type  = sel3 ? type3  : type1;
        o_bin   = sel3 ? bin3   : bin1;
        o_idx   = sel3 ? idx3   : idx1;
        o_nz    = sel3 ? nz3    : nz1;
        o_data  = sel3 ? data3  : data1;
    end

    // Engine clause array model with configurable read latency
    logic [15:0] cmem [NC];
    logic [15:0] e1_p1, e3_p1, e3_p2, e3_p3;

    function automatic logic [15:0] lookup(input logic [NC-1:0] rd);
        logic [15:0] r;
        r = '0;
        for (int j = 0; j < NC; j++) if (rd[j]) r = r | cmem[j];
        return r;
    endfunction

    always @(posedge clk) begin
        e1_p1 <= lookup(rd1);
        e3_p1 <= lookup(rd3);
        e3_p2 <= e3_p1;
        e3_p3 <= e3_p2;
    end
    assign clause1 = e1_p1;
    assign clause3 = e3_p3;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]    t;
        logic [3:0]    idx;
        logic [WD-1:0] data;
    } exp_t;
    exp_t sbq[$];

    // disturb: 0 none, 1 restart pulse + var change mid-run, 2 reset during WR_V
    task automatic unload(input logic s3, input logic [9:0] bin, input int rmode,
                          input logic [3:0] exp_nz, input int disturb, output int lat);
        exp_t e;
        int n, dones, strobes;
        logic pv, pr;
        logic [1:0] pt;
        logic [3:0] pi;
        logic [WD-1:0] pd;
        logic [NC-1:0] prd;
        sbq.delete();
        for (int i = 0; i < NC; i++) begin
            e.t = WR_TYPE_CLAUSE; e.idx = 4'(i); e.data = WD'(cmem[i]);
            sbq.push_back(e);
        end
        for (int i = 0; i < NV; i++) begin
            e.t = WR_TYPE_VAR; e.idx = 4'(i); e.data = WD'(vars[i*WVS +: WVS]);
            sbq.push_back(e);
        end
        for (int i = 0; i < NL; i++) begin
            e.t = WR_TYPE_LVL; e.idx = 4'(i); e.data = WD'(lvls[i*WLS +: WLS]);
            sbq.push_back(e);
        end
        sel3 = s3;
        lat = -1;
        dones = 0; strobes = 0;
        pv = 1'b0; pr = 1'b0; pt = '0; pi = '0; pd = '0; prd = '0;
        bin_id = bin;
        if (s3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0;
        bin_id = ~bin;
        n = 1;
        while (n <= 1000) begin
            if (o_rd != '0) begin
                strobes++;
                chk("rd_onehot", 32'($onehot(o_rd)), 32'd1);
                chk("rd_single_cycle", 32'(prd), 32'd0);
            end
            prd = o_rd;
            if (disturb == 1 && n == 5) begin
                if (s3) start3 = 1'b1; else start1 = 1'b1;
                vars = ~vars;
            end else begin
                start1 = 1'b0; start3 = 1'b0;
            end
            if (disturb == 2 && o_valid && o_type == WR_TYPE_VAR) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk("abort_valid", 32'(o_valid), 32'd0);
                chk("abort_busy", 32'(o_busy), 32'd0);
                chk("abort_rd", 32'(o_rd), 32'd0);
                chk("abort_done", 32'(o_done), 32'd0);
                rst = 1'b0;
                sbq.delete();
                lat = -2;
                return;
            end
            if (pv && !pr) begin
                chk("stall_valid", 32'(o_valid), 32'd1);
                chk("stall_data", 32'(o_data), 32'(pd));
                chk("stall_idx", 32'(o_idx), 32'(pi));
                chk("stall_type", 32'(o_type), 32'(pt));
            end
            if (o_done) begin
                dones++;
                if (dones == 1) begin
                    lat = n;
                    chk("nz_count", 32'(o_nz), 32'(exp_nz));
                    chk("busy_at_done", 32'(o_busy), 32'd0);
                    chk("writes_left", 32'(sbq.size()), 32'd0);
                end
            end else if (dones == 0) begin
                chk("busy_during", 32'(o_busy), 32'd1);
            end
            if (lat > 0 && n >= lat + 4) break;
            ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (o_valid && ready) begin
                if (sbq.size() == 0) begin
                    chk("extra_write", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_type", 32'(o_type), 32'(e.t));
                    chk("wr_idx", 32'(o_idx), 32'(e.idx));
                    chk("wr_data", 32'(o_data), 32'(e.data));
                    chk("wr_bin", 32'(o_bin), 32'(bin));
                end
            end
            pv = o_valid; pr = ready; pt = o_type; pi = o_idx; pd = o_data;
            @(posedge clk); #1;
            n++;
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
        chk("done_count", 32'(dones), 32'd1);
        chk("strobe_count", 32'(strobes), 32'd8);
        chk("nz_held", 32'(o_nz), 32'(exp_nz));
    endtask

    typedef struct {
        logic       s3;
        logic [9:0] bin;
        int         rmode;
        int         exp_lat;
        logic [3:0] exp_nz;
    } vec_t;
    vec_t vecs[4];

    int val_v[8] = '{1, 1, 1, 2, 0, 0, 0, 0};
    int imp_v[8] = '{1, 0, 1, 1, 0, 0, 0, 0};
    int lev_v[8] = '{0, 1, 2, 1, 0, 0, 0, 0};
    int dcd_v[8] = '{2, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int lat;
        logic [WVS*NV-1:0] vars_saved;
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; ready = 1'b0; sel3 = 1'b0;
        bin_id = '0;
        for (int j = 0; j < NC; j++) cmem[j] = '0;
        cmem[0] = 16'h0012;
        cmem[1] = 16'h0009;
        cmem[2] = 16'h8000;
        for (int j = 0; j < NV; j++)
            vars[j*WVS +: WVS] = {4'(j), 12'(lev_v[j]), 1'(imp_v[j]), 2'(val_v[j])};
        for (int j = 0; j < NL; j++)
            lvls[j*WLS +: WLS] = {4'(j + 1), 7'(dcd_v[j])};

        vecs[0] = '{1'b0, 10'd5,   0, 41, 4'd3};
        vecs[1] = '{1'b0, 10'd5,   1, -1, 4'd3};
        vecs[2] = '{1'b1, 10'h3FF, 0, 57, 4'd3};
        vecs[3] = '{1'b1, 10'h2A,  1, -1, 4'd3};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'({busy1, busy3}), 32'd0);
        chk("rst_done", 32'({done1, done3}), 32'd0);
        chk("rst_valid", 32'({valid1, valid3}), 32'd0);
        chk("rst_rd", 32'({rd1, rd3}), 32'd0);
        chk("rst_nz", 32'({nz1, nz3}), 32'd0);
        chk("rst_bin_idx", 32'({bin1, idx1, bin3, idx3}), 32'd0);
        chk("rst_data", 32'(data1 | data3), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            unload(vecs[i].s3, vecs[i].bin, vecs[i].rmode, vecs[i].exp_nz, 0, lat);
            if (vecs[i].exp_lat > 0) chk("latency", 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Restart pulse and var change while busy
        vars_saved = vars;
        unload(1'b0, 10'd7, 0, 4'd3, 1, lat);
        chk("restart_latency", 32'(lat), 32'd41);
        vars = vars_saved;

        // Different clause contents, live per strobe
        cmem[5] = 16'hFFFF;
        unload(1'b1, 10'd3, 1, 4'd4, 0, lat);
        cmem[5] = '0;

        // Reset during WR_V, then a fresh complete unload
        unload(1'b0, 10'd5, 0, 4'd3, 2, lat);
        chk("abort_path", 32'(lat), 32'hFFFFFFFE);
        @(posedge clk); #1;
        unload(1'b0, 10'd9, 0, 4'd3, 0, lat);
        chk("post_abort_latency", 32'(lat), 32'd41);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sat_engine_unloader.md
Name: sat_engine_unloader

Overview:
- Read-back controller for one sat_engine bin after `done_core_o`. It is the reading end of the engine's load/update port.
- Sequences one-hot `rd_carray` strobes over every clause slot and captures `clause_o`.
- Snapshots `vars_states_o` and `lvl_states_o`.
- Streams all entries into the bin store over a valid/ready write channel, tagged with bin id, entry type and index.
- Sits between sat_engine and the bin memory controller in the top-level bin manager.

Parameters:
- NUM_CLAUSES, 8, clause slots in the engine clause array.
- NUM_VARS, 8, local variables per bin; a clause is NUM_VARS*2 bits.
- NUM_LVLS, 8, level-state entries.
- WIDTH_BIN_ID, 10, bin id width.
- WIDTH_VAR_STATES, 19, bits per variable state.
- WIDTH_LVL_STATES, 11, bits per level state.
- RD_LATENCY, 1, cycles from `rd_carray_o` strobe to valid `clause_i` (allowed range 1..3).
- WIDTH_DATA, 19, write data width. Must be >= NUM_VARS*2, WIDTH_VAR_STATES and WIDTH_LVL_STATES.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start_i  in  1  one-cycle request to unload; sampled only in IDLE
- bin_id_i  in  WIDTH_BIN_ID  bin being unloaded; latched on start
- busy_o  out  1  high from the cycle after start until done_o
- done_o  out  1  one-cycle pulse when all entries are written
- rd_carray_o  out  NUM_CLAUSES  one-hot clause read strobe to the engine
- clause_i  in  NUM_VARS*2  engine `clause_o`
- vars_states_i  in  WIDTH_VAR_STATES*NUM_VARS  engine `vars_states_o`
- lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS  engine `lvl_states_o`
- wr_valid_o  out  1  write request valid
- wr_ready_i  in  1  bin store accepts
- wr_type_o  out  2  entry type: 0 clause, 1 var state, 2 lvl state
- wr_bin_o  out  WIDTH_BIN_ID  latched bin id
- wr_idx_o  out  4  entry index within its type
- wr_data_o  out  WIDTH_DATA  entry, zero-extended
- nz_clause_cnt_o  out  4  count of non-zero clauses in the last unload; valid with done_o and held until the next start

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters 0, snapshot registers 0. Reset mid-operation aborts immediately; no further strobes or writes.
- IDLE: on start_i=1:
  - latch bin_id_i;
  - snapshot vars_states_i and lvl_states_i into registers;
  - clear idx and nz counter;
  - go to RD_C.
- RD_C: drive `rd_carray_o[idx]=1` for exactly one cycle, then go to WAIT_C.
- WAIT_C: count RD_LATENCY cycles. On the edge ending the last one, capture clause_i into the hold register and go to WR_C.
- WR_C:
  - wr_valid_o=1, type 0, idx, data = held clause.
  - wr_data_o and wr_idx_o stay stable while valid and not ready.
  - On the handshake: increment nz counter if held clause != 0.
  - If idx==NUM_CLAUSES-1: idx=0 and go to WR_V. Otherwise idx++ and go to RD_C.
- WR_V:
  - type 1, data = snapshot var slice [idx*WIDTH_VAR_STATES +: WIDTH_VAR_STATES].
  - One entry per handshake; back-to-back when ready stays high.
  - After idx NUM_VARS-1: idx=0 and go to WR_L.
- WR_L:
  - type 2, data = lvl slice [idx*WIDTH_LVL_STATES +: WIDTH_LVL_STATES].
  - After idx NUM_LVLS-1 handshakes, go to DONE.
- DONE:
  - done_o=1 for one cycle; nz_clause_cnt_o updates in this cycle.
  - busy_o=0 in this cycle; go to IDLE.
- Only one strobe per clause. rd_carray_o is never asserted outside RD_C and is never multi-hot.
- A low wr_ready_i stalls the FSM indefinitely with no data change. A ready without valid is ignored.
- start_i while busy: ignored, no queuing.
- Engine inputs changing after start do not affect var/lvl writes (snapshot). Clause data is taken live per strobe.
- Latency with wr_ready_i=1 and RD_LATENCY=1:
  - 3 cycles per clause, 1 per var, 1 per lvl;
  - start edge to done_o = 8*3+8+8+1 = 41 cycles.

Decomposition:
- Shared package sat_pkg holds:
  - entry-type constants WR_TYPE_CLAUSE=0, WR_TYPE_VAR=1, WR_TYPE_LVL=2;
  - FSM state enum unload_state_t (IDLE, RD_C, WAIT_C, WR_C, WR_V, WR_L, DONE);
  - literal encoding constants LIT_NONE=0, LIT_NEG=1, LIT_POS=2.
- The whole block is one module with no sub-module. The write channel is a plain registered valid/ready source, with no skid buffer needed.

Test Plan:
- Load the engine with clause 0 lits {2,0,1,0,0,0,0,0} (bits[2j+1:2j]=lit of var j), clauses 1 and 2 per the cur_bin_num=1 case, others 0. Start with bin_id 5 and ready high -> expected:
  - 8 type-0 writes, idx 0..7;
  - idx0 data 16'h0012;
  - nz_clause_cnt_o=3;
  - done_o exactly 41 cycles after start.
- Var states value {1,1,1,2,0,0,0,0}, implied {1,0,1,1,0,...}, level {0,1,2,1,0,...}; lvl dcd_bin {2,0,...} -> type-1 and type-2 writes match the snapshot slices bit-exact, idx 0..7 each, wr_bin_o=5 throughout.
- wr_ready_i toggling pseudo-randomly, low 50% -> identical write sequence:
  - data stable during stalls;
  - rd_carray_o strobes exactly 8 times, each one-hot, one cycle.
- RD_LATENCY=3 with the engine model returning clause 3 cycles after the strobe -> correct clause captured; 5 cycles per clause; done at 57 cycles.
- start_i pulsed again mid-unload, and engine var states changed after start -> start ignored; var writes show the old snapshot; only one done_o.
- rst asserted during WR_V -> next cycle:
  - wr_valid_o=0, busy_o=0, rd_carray_o=0;
  - a fresh start then completes a full 24-write unload.
